error_cmd_sequencer: RTL and testbench

- Synchronous controller that sequences the error-angle level pulses (UPLVL/DNLVL) driving the error-angle ladder.
- Accepts AGC error-counter up/down commands and queues them as a signed pending count.
- Issues at most one level pulse per FAZ2 phase strobe and tracks the resulting error count, clamped to ±LIMIT.
- When the error counter is disabled, it ramps the count back to zero one pulse per phase.

---
 rtl/err_seq_pkg.sv | 16 +
 rtl/sat_acc.sv | 33 +++
 rtl/error_cmd_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_error_cmd_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_seq_pkg.sv
// Shared types and default constants for the error-angle command sequencer.
package err_seq_pkg;

    // Sequencer operating state.
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2,
        ZERO     = 2'd3
    } seq_state_e;

    localparam int unsigned ERR_LIMIT  = 384;
    localparam int unsigned ERR_CNT_W  = 10;
    localparam int unsigned ERR_PEND_W = 8;

endpackage

// File: rtl/sat_acc.sv
// Signed saturating accumulator for the pending-command count.
// The next value is i_acc + i_delta - i_dec, clamped to +/-(2^(W-1)-1).
//   i_acc   : current accumulator value
//   i_delta : incoming command (-1/0/+1)
//   i_dec   : issue direction removed this cycle (-1/0/+1)
//   o_sum   : saturated result
module sat_acc #(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] i_acc,
    input  logic signed [1:0]   i_delta,
    input  logic signed [1:0]   i_dec,
    output logic signed [W-1:0] o_sum
);

    localparam logic signed [W+1:0] MAX_P = (W+2)'((2 ** (W - 1)) - 1);
    localparam logic signed [W+1:0] MAX_N = -MAX_P;

    logic signed [W+1:0] w_raw;

    // Two guard bits keep the unclamped sum exact before saturation.
    always_comb begin
        w_raw = (W+2)'(i_acc) + (W+2)'(i_delta) - (W+2)'(i_dec);
        if (w_raw > MAX_P) begin
            o_sum = W'(MAX_P);
        end else if (w_raw < MAX_N) begin
            o_sum = W'(MAX_N);
        end else begin
            o_sum = W'(w_raw);
        end
    end

endmodule

// File: rtl/error_cmd_sequencer.sv
// Error-angle level pulse sequencer. Queues AGC up/down commands as a
// signed pending count, issues at most one UPLVL/DNLVL pulse per FAZ2
// strobe, tracks the resulting error count clamped to +/-LIMIT, and ramps
// the count back to zero when the error counter is disabled.
// Optional: ERR_CMD_SEQ_OVF_FLAG_EN adds a sticky ovf output flagging
// commands dropped at pend saturation or discarded at the LIMIT clamp.
//   clk, rst  : clock, asynchronous active-high reset
//   faz2_stb  : pulse issue slot
//   err_en    : error counter enable
//   cmd_up/dn : one-cycle increment/decrement commands
//   uplvl/dnlvl : one-cycle level pulses
//   err_cnt   : signed error count
//   pend      : signed pending commands
//   busy      : high in RUN or ZERO
//   at_limit  : high while |err_cnt| == LIMIT
module error_cmd_sequencer
    import err_seq_pkg::*;
#(
    parameter int unsigned CNT_W  = ERR_CNT_W,
    parameter int unsigned PEND_W = ERR_PEND_W,
    parameter int unsigned LIMIT  = ERR_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     faz2_stb,
    input  logic                     err_en,
    input  logic                     cmd_up,
    input  logic                     cmd_dn,
    output logic                     uplvl,
    output logic                     dnlvl,
    output logic signed [CNT_W-1:0]  err_cnt,
    output logic signed [PEND_W-1:0] pend,
    output logic                     busy,
    output logic                     at_limit
`ifdef ERR_CMD_SEQ_OVF_FLAG_EN
    ,
    output logic                     ovf
`endif
);

    localparam logic signed [CNT_W-1:0] LIM_P = CNT_W'(LIMIT);
    localparam logic signed [CNT_W-1:0] LIM_N = -LIM_P;

    seq_state_e               r_state;
    logic signed [PEND_W-1:0] r_pend;
    logic signed [CNT_W-1:0]  r_cnt;
    logic                     r_up;
    logic                     r_dn;
    logic                     r_busy;
    logic                     r_at_limit;

    logic                     w_active;
    logic signed [1:0]        w_delta;
    logic signed [1:0]        w_acc_delta;
    logic signed [1:0]        w_issue;
    logic signed [PEND_W-1:0] w_pend_sum;
    logic signed [CNT_W-1:0]  w_cnt_nxt;
    logic                     w_up_nxt;
    logic                     w_dn_nxt;
    logic                     w_pend_pos;
    logic                     w_pend_neg;
    logic                     w_cnt_pos;
    logic                     w_cnt_neg;

    // Command decode, issue decision and error-count next value.
    always_comb begin
        w_delta = 2'sb00;
        if (cmd_up && !cmd_dn) begin
            w_delta = 2'sb01;
        end else if (cmd_dn && !cmd_up) begin
            w_delta = 2'sb11;
        end

        w_active    = err_en && ((r_state == IDLE) || (r_state == RUN));
        w_acc_delta = w_active ? w_delta : 2'sb00;

        w_pend_neg = r_pend[PEND_W-1];
        w_pend_pos = !w_pend_neg && (r_pend != '0);
        w_cnt_neg  = r_cnt[CNT_W-1];
        w_cnt_pos  = !w_cnt_neg && (r_cnt != '0);

        // One pending command is consumed per strobe even when clamped.
        w_issue = 2'sb00;
        if (w_active && (r_state == RUN) && faz2_stb) begin
            if (w_pend_pos) begin
                w_issue = 2'sb01;
            end else if (w_pend_neg) begin
                w_issue = 2'sb11;
            end
        end

        w_up_nxt  = 1'b0;
        w_dn_nxt  = 1'b0;
        w_cnt_nxt = r_cnt;
        if ((w_issue == 2'sb01) && (r_cnt < LIM_P)) begin
            w_up_nxt  = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if ((w_issue == 2'sb11) && (r_cnt > LIM_N)) begin
            w_dn_nxt  = 1'b1;
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if ((r_state == ZERO) && faz2_stb) begin
            if (w_cnt_pos) begin
                w_dn_nxt  = 1'b1;
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (w_cnt_neg) begin
                w_up_nxt  = 1'b1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Pending-command accumulator: command and issue apply in the same cycle.
    sat_acc #(
        .W (PEND_W)
    ) u_pend_acc (
        .i_acc   (r_pend),
        .i_delta (w_acc_delta),
        .i_dec   (w_issue),
        .o_sum   (w_pend_sum)
    );

    // Sequencer FSM with registered pulses and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DISABLED;
            r_pend     <= '0;
            r_cnt      <= '0;
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
            r_busy     <= 1'b0;
            r_at_limit <= 1'b0;
        end else begin
            r_up       <= w_up_nxt;
            r_dn       <= w_dn_nxt;
            r_cnt      <= w_cnt_nxt;
            r_at_limit <= (w_cnt_nxt == LIM_P) || (w_cnt_nxt == LIM_N);
            case (r_state)
                DISABLED: begin
                    r_busy <= 1'b0;
                    if (err_en) begin
                        r_state <= IDLE;
                    end
                end
                IDLE, RUN: begin
                    if (!err_en) begin
                        r_state <= ZERO;
                        r_pend  <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_pend <= w_pend_sum;
                        if (w_pend_sum != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ZERO: begin
                    if (w_cnt_nxt == '0) begin
                        r_state <= err_en ? IDLE : DISABLED;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DISABLED;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uplvl    = r_up;
    assign dnlvl    = r_dn;
    assign err_cnt  = r_cnt;
    assign pend     = r_pend;
    assign busy     = r_busy;
    assign at_limit = r_at_limit;

`ifdef ERR_CMD_SEQ_OVF_FLAG_EN
    logic r_ovf;
    logic r_en_q;
    logic w_drop;

    // A command with no effect on the sum was dropped at saturation;
    // an issue that could not move err_cnt was discarded at the clamp.
    always_comb begin
        w_drop = ((w_acc_delta != 2'sb00) &&
                  (w_pend_sum == (r_pend - PEND_W'(w_issue)))) ||
                 ((w_issue == 2'sb01) && (r_cnt == LIM_P)) ||
                 ((w_issue == 2'sb11) && (r_cnt == LIM_N));
    end

    // Sticky flag, cleared on the falling edge of err_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= err_en;
            if (r_en_q && !err_en) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_error_cmd_sequencer.sv
// Self-checking bench for error_cmd_sequencer: a behavioural model pushes
// expected pulses (with their cycle) into a scoreboard queue; the monitor
// pops them as the DUT pulses. Status outputs are checked at checkpoints.
module tb_error_cmd_sequencer;

    localparam int CNT_W  = 10;
    localparam int PEND_W = 8;
    localparam int LIMIT  = 384;
    localparam int PMAX   = 127;

    logic                     clk;
    logic                     rst;
    logic                     faz2_stb;
    logic                     err_en;
    logic                     cmd_up;
    logic                     cmd_dn;
    logic                     uplvl;
    logic                     dnlvl;
    logic signed [CNT_W-1:0]  err_cnt;
    logic signed [PEND_W-1:0] pend;
    logic                     busy;
    logic                     at_limit;
`ifdef ERR_CMD_SEQ_OVF_FLAG_EN
    logic                     ovf;
`endif

    error_cmd_sequencer #(
        .CNT_W  (CNT_W),
        .PEND_W (PEND_W),
        .LIMIT  (LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .faz2_stb (faz2_stb),
        .err_en   (err_en),
        .cmd_up   (cmd_up),
        .cmd_dn   (cmd_dn),
        .uplvl    (uplvl),
        .dnlvl    (dnlvl),
        .err_cnt  (err_cnt),
        .pend     (pend),
        .busy     (busy),
        .at_limit (at_limit)
`ifdef ERR_CMD_SEQ_OVF_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit up;
        bit dn;
    } pulse_t;

    pulse_t sb_q[$];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int n_up     = 0;
    int n_dn     = 0;

    // Model state: 0 DISABLED, 1 IDLE, 2 RUN, 3 ZERO.
    int m_state   = 0;
    int m_cnt     = 0;
    int m_pend    = 0;
    bit m_ovf     = 0;
    bit m_prev_en = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_cnt     = 0;
        m_pend    = 0;
        m_ovf     = 0;
        m_prev_en = 0;
        sb_q.delete();
    endtask

    task automatic model_step(input bit up, input bit dn, input bit stb, input bit en);
        int d;
        int iss;
        int raw;
        bit pu;
        bit pd;
        bit drop;
        pu   = 0;
        pd   = 0;
        drop = 0;
        d    = int'(up) - int'(dn);
        case (m_state)
            0: if (en) m_state = 1;
            1, 2: begin
                if (!en) begin
                    m_state = 3;
                    m_pend  = 0;
                end else begin
                    iss = 0;
                    if (m_state == 2 && stb) iss = (m_pend > 0) ? 1 : ((m_pend < 0) ? -1 : 0);
                    if (iss == 1) begin
                        if (m_cnt < LIMIT) begin m_cnt++; pu = 1; end else drop = 1;
                    end else if (iss == -1) begin
                        if (m_cnt > -LIMIT) begin m_cnt--; pd = 1; end else drop = 1;
                    end
                    raw = m_pend + d - iss;
                    if (raw > PMAX) begin raw = PMAX; drop = 1; end
                    else if (raw < -PMAX) begin raw = -PMAX; drop = 1; end
                    m_pend  = raw;
                    m_state = (raw != 0) ? 2 : 1;
                end
            end
            default: begin
                if (stb) begin
                    if (m_cnt > 0) begin m_cnt--; pd = 1; end
                    else if (m_cnt < 0) begin m_cnt++; pu = 1; end
                end
                if (m_cnt == 0) m_state = en ? 1 : 0;
            end
        endcase
        if (m_prev_en && !en) m_ovf = 0;
        else if (drop) m_ovf = 1;
        m_prev_en = en;
        if (pu || pd) sb_q.push_back('{cyc: cyc, up: pu, dn: pd});
    endtask

    // One clock: drive inputs, advance model, then compare pulses after the edge.
    task automatic step(input bit up, input bit dn, input bit stb);
        pulse_t e;
        cmd_up   = up;
        cmd_dn   = dn;
        faz2_stb = stb;
        @(posedge clk);
        cyc++;
        model_step(up, dn, stb, err_en);
        #1;
        if (uplvl) n_up++;
        if (dnlvl) n_dn++;
        if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            check_val("pulse", int'({uplvl, dnlvl}), int'({e.up, e.dn}));
        end else if (uplvl || dnlvl) begin
            check_val("pulse_extra", int'({uplvl, dnlvl}), 0);
        end
        cmd_up   = 1'b0;
        cmd_dn   = 1'b0;
        faz2_stb = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_val({tag, "_cnt"},  int'(err_cnt), m_cnt);
        check_val({tag, "_pend"}, int'(pend), m_pend);
        check_val({tag, "_busy"}, int'(busy), int'(m_state == 2 || m_state == 3));
        check_val({tag, "_lim"},  int'(at_limit), int'(m_cnt == LIMIT || m_cnt == -LIMIT));
`ifdef ERR_CMD_SEQ_OVF_FLAG_EN
        check_val({tag, "_ovf"},  int'(ovf), int'(m_ovf));
`endif
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_up"},   int'(uplvl), 0);
        check_val({tag, "_dn"},   int'(dnlvl), 0);
        check_val({tag, "_cnt"},  int'(err_cnt), 0);
        check_val({tag, "_pend"}, int'(pend), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_lim"},  int'(at_limit), 0);
`ifdef ERR_CMD_SEQ_OVF_FLAG_EN
        check_val({tag, "_ovf"},  int'(ovf), 0);
`endif
    endtask

    int up0;
    int dn0;

    initial begin
        rst      = 1'b1;
        err_en   = 1'b0;
        cmd_up   = 1'b0;
        cmd_dn   = 1'b0;
        faz2_stb = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;

        // Three up commands, strobes every 8 cycles.
        err_en = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 0, (i % 8) == 7);
        check_model("up3");
        check_val("up3_cnt_const", int'(err_cnt), 3);
        check_val("up3_npulse", n_up, 3);
        check_val("up3_idle", int'(busy), 0);

        // Simultaneous up and down cancel.
        up0 = n_up;
        dn0 = n_dn;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0);
            step(0, 0, 1);
        end
        check_val("both_pend", int'(pend), 0);
        check_val("both_pulses", (n_up - up0) + (n_dn - dn0), 0);

        // Climb to 383 with pend 4, then hit the clamp.
        for (int i = 0; i < 380; i++) step(1, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        check_val("pre_cnt", int'(err_cnt), 383);
        check_val("pre_pend", int'(pend), 4);
        up0 = n_up;
        for (int i = 0; i < 16; i++) step(0, 0, (i % 4) == 0);
        check_val("clamp_cnt", int'(err_cnt), LIMIT);
        check_val("clamp_lim", int'(at_limit), 1);
        check_val("clamp_pend", int'(pend), 0);
        check_val("clamp_npulse", n_up - up0, 1);
        check_model("clamp");

        // Pending saturation on the negative side.
        for (int i = 0; i < 200; i++) step(0, 1, 0);
        check_val("sat_pend", int'(pend), -PMAX);
        check_model("sat");

        // Disable from the limit: full ramp to zero, commands ignored.
        err_en = 1'b0;
        step(0, 0, 0);
        check_val("z1_pend", int'(pend), 0);
        check_val("z1_busy", int'(busy), 1);
        dn0 = n_dn;
        for (int i = 0; i < LIMIT; i++) step(i % 2 == 0, i % 3 == 0, 1);
        step(0, 0, 0);
        check_val("z1_ndn", n_dn - dn0, LIMIT);
        check_model("z1_done");

        // err_cnt = 5 with pend = 2, then disable.
        err_en = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        check_val("z2_cnt0", int'(err_cnt), 5);
        check_val("z2_pend0", int'(pend), 2);
        err_en = 1'b0;
        step(0, 0, 0);
        check_val("z2_pend", int'(pend), 0);
        dn0 = n_dn;
        for (int i = 0; i < 18; i++) step(1, i % 2 == 1, (i % 3) == 2);
        check_val("z2_ndn", n_dn - dn0, 5);
        check_val("z2_cnt", int'(err_cnt), 0);
        check_val("z2_disabled", int'(busy), 0);
        check_model("z2");

        // Negative count ramps back with up pulses.
        err_en = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check_val("neg_cnt", int'(err_cnt), -3);
        err_en = 1'b0;
        up0 = n_up;
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        check_val("neg_nup", n_up - up0, 3);
        check_model("neg");

        // Reset while uplvl is high.
        err_en = 1'b1;
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        check_val("mid_uplvl", int'(uplvl), 1);
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        check_model("post_rst");
        check_val("post_rst_cnt", int'(err_cnt), 1);

        check_val("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
